apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
- Two-requester arbiter placed in front of the APB master's CPU-side port (transfer/ready/write/addr/wdata/rdata).
- Lets the RV32I core (requester 0) and a second bus initiator such as a DMA or debug loader (requester 1) share the single APB master and its peripherals (RAM, GPO, GPI, GPIO, UART).
- Serialises transactions, latches each request, and returns read data and a ready pulse to the winner.
- Includes a ready-timeout watchdog so a stalled peripheral cannot hang the bus.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- ARB_MODE, 0, 0 = round-robin; 1 = fixed priority with requester 0 highest.
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before forced completion; must be ≥ 2.
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on timeout.

Ports:
- PCLK  in  1  clock
- PRESET  in  1  synchronous active-high reset
- transfer0  in  1  requester 0 request; held until ready0
- write0  in  1  requester 0: 1 = write
- addr0  in  ADDR_W  requester 0 address
- wdata0  in  DATA_W  requester 0 write data
- rdata0  out  DATA_W  requester 0 read data
- ready0  out  1  requester 0 completion pulse
- transfer1  in  1  requester 1 request
- write1  in  1  requester 1: 1 = write
- addr1  in  ADDR_W  requester 1 address
- wdata1  in  DATA_W  requester 1 write data
- rdata1  out  DATA_W  requester 1 read data
- ready1  out  1  requester 1 completion pulse
- transfer  out  1  to APB master: start pulse
- write  out  1  to APB master
- addr  out  ADDR_W  to APB master
- wdata  out  DATA_W  to APB master
- rdata  in  DATA_W  from APB master
- ready  in  1  from APB master: completion
- grant_id  out  1  requester currently or last served
- busy  out  1  1 when state ≠ IDLE
- timeout_err  out  1  sticky timeout flag
- err_clr  in  1  clears timeout_err

Behaviour:
- Interface: one clock, PCLK; reset PRESET is synchronous, active-high.
- Reset values:
  - state = IDLE, last_grant = 1 (requester 0 wins the first tie).
  - All outputs 0: transfer, write, addr, wdata, ready0/1, rdata0/1, busy, timeout_err, grant_id.
  - Timeout counter = 0.
- Requester contract:
  - Assert transferN with stable writeN/addrN/wdataN until the cycle readyN = 1.
  - Deassert no later than the following cycle; the arbiter ignores transferN during RESP.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any transferN is high, pick a winner:
    - ARB_MODE 0: if both request, grant the requester ≠ last_grant; otherwise grant the sole requester.
    - ARB_MODE 1: requester 0 whenever it requests.
  - On the clock edge: latch the winner's write/addr/wdata into output registers, set grant_id and last_grant, go to ISSUE.
- ISSUE: transfer = 1 for exactly one cycle. If ready = 1 in this cycle, capture rdata and go to RESP; otherwise go to WAIT.
- WAIT:
  - transfer = 0; addr/write/wdata are held stable.
  - Counter increments each cycle.
  - ready = 1: capture rdata, go to RESP.
  - Counter reaches TIMEOUT_CYCLES with no ready: capture ERR_DATA, set timeout_err, go to RESP.
  - ready and timeout in the same cycle: ready wins, and timeout_err is not set.
- RESP:
  - ready[grant_id] = 1 for one cycle; rdata[grant_id] = captured value.
  - The other requester's rdata holds its previous value.
  - Go to IDLE next cycle; counter resets.
- Latency:
  - Request-to-transfer: 1 cycle.
  - ready-to-readyN: 1 cycle.
  - Minimum gap between back-to-back grants: one IDLE cycle.
- A request arriving mid-transaction waits; no preemption.
- ready seen in IDLE or RESP is ignored.
- Write transactions still return readyN; rdataN takes the captured bus rdata.
- timeout_err: set dominates err_clr when both occur in the same cycle.
- PRESET mid-transaction: immediate return to IDLE with reset values; no readyN is issued for the aborted request.

Decomposition:
- Package apb_arb_pkg: typedef enum arb_state_e {IDLE, ISSUE, WAIT, RESP}; localparam for ARB_MODE encodings.
- One natural sub-module: apb_arb_timeout_cnt (counter with clear, enable, and terminal flag).

Test Plan:
1. Requester 0 only, read addr 0x1000_0004; ready after 2 WAIT cycles with rdata 0x0000_00A5 → one transfer pulse, then ready0 pulse with rdata0 = 0x0000_00A5; ready1 never asserts.
2. Both request in the same cycle, ARB_MODE 0, repeated 4 times → grants alternate 0, 1, 0, 1; each requester's write (wdata 0x11 / 0x22) reaches the bus with its own addr.
3. ARB_MODE 1 with requester 0 re-requesting continuously → requester 1 is never granted while transfer0 is high; it is granted in the first IDLE after transfer0 drops.
4. ready never asserted, TIMEOUT_CYCLES = 8 → readyN at cycle 8 of WAIT + 1, rdataN = 0xDEAD_BEEF, timeout_err = 1; err_clr pulse → timeout_err = 0.
5. ready in the same cycle as timeout → real rdata is returned and timeout_err stays 0.
6. PRESET asserted during WAIT → the next cycle has busy = 0, transfer = 0, ready0/1 = 0, state IDLE; a new request afterwards is served normally.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared definitions for the two-requester APB master arbiter.
//   arb_state_e : arbiter FSM states
//   ARB_RR/ARB_FIXED : encodings of the ARB_MODE parameter
//   pick_winner : winner selection for the IDLE decision
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Returns the requester index to grant. Only meaningful when at least
    // one request is present. A lone requester always wins; a tie goes to
    // the side not served last (round-robin) or to requester 0 (fixed).
    function automatic logic pick_winner(input int mode, input logic req0,
                                         input logic req1, input logic last);
        if (req0 && req1) begin
            case (mode)
                ARB_RR:    return ~last;
                ARB_FIXED: return 1'b0;
                default:   return 1'b0;
            endcase
        end
        return req0 ? 1'b0 : 1'b1;
    endfunction

endpackage

// File: rtl/apb_arb_timeout_cnt.sv
// Ready-timeout counter for the APB arbiter.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (held while not waiting on the bus)
//   en       : count enable, one increment per enabled cycle
//   term     : high in the enabled cycle in which the count reaches MAX,
//              i.e. the MAX-th consecutive enabled cycle
// MAX must be at least 2 so that the first WAIT cycle is never terminal.
module apb_arb_timeout_cnt #(
    parameter int MAX = 255,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic term
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + W'(1);
    end

    assign term = en && (cnt == W'(MAX - 1));

endmodule

// File: rtl/apb_master_arbiter.sv
// Two-requester arbiter in front of the APB master's CPU-side port.
// Requester 0 is the RV32I core, requester 1 a second initiator (DMA /
// debug loader). One transaction is in flight at a time; the winner's
// request is latched, issued as a one-cycle transfer pulse, and its
// read data and a one-cycle readyN pulse are returned when the APB
// master completes or the ready watchdog expires.
//   PCLK, PRESET            : clock, synchronous active-high reset
//   transferN/writeN/addrN/wdataN : requester N request (held until readyN)
//   rdataN/readyN           : requester N response
//   transfer/write/addr/wdata : request to the APB master
//   rdata/ready             : completion from the APB master
//   grant_id                : requester currently or last served
//   busy                    : a transaction is in progress
//   timeout_err/err_clr     : sticky watchdog flag and its clear
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                ARB_MODE       = ARB_RR,
    parameter int                TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              transfer0,
    input  logic              write0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic [DATA_W-1:0] rdata0,
    output logic              ready0,
    input  logic              transfer1,
    input  logic              write1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata1,
    output logic              ready1,
    output logic              transfer,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              ready,
    output logic              grant_id,
    output logic              busy,
    output logic              timeout_err,
    input  logic              err_clr
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e        state;
    logic              last_grant;
    logic              win;
    logic              to_term;
    logic              cap_en;
    logic              to_hit;
    logic [DATA_W-1:0] cap_data;

    assign win = pick_winner(ARB_MODE, transfer0, transfer1, last_grant);

    // Counts only while waiting; any other state holds it at zero so every
    // transaction starts its watchdog from scratch.
    apb_arb_timeout_cnt #(
        .MAX (TIMEOUT_CYCLES),
        .W   (CW)
    ) u_timeout (
        .clk  (PCLK),
        .rst  (PRESET),
        .clr  (state != WAIT),
        .en   (state == WAIT),
        .term (to_term)
    );

    // Completion capture: a real ready always beats the watchdog, so the
    // error path fires only when the terminal WAIT cycle sees no ready.
    always_comb begin
        cap_en   = 1'b0;
        to_hit   = 1'b0;
        cap_data = rdata;
        if ((state == ISSUE || state == WAIT) && ready) begin
            cap_en = 1'b1;
        end else if (state == WAIT && to_term) begin
            cap_en   = 1'b1;
            to_hit   = 1'b1;
            cap_data = ERR_DATA;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            grant_id    <= 1'b0;
            write       <= 1'b0;
            addr        <= '0;
            wdata       <= '0;
            rdata0      <= '0;
            rdata1      <= '0;
            timeout_err <= 1'b0;
        end else begin
            // Later assignment wins: a timeout in the same cycle keeps the flag set.
            if (err_clr) timeout_err <= 1'b0;
            if (to_hit)  timeout_err <= 1'b1;

            if (cap_en) begin
                if (grant_id) rdata1 <= cap_data;
                else          rdata0 <= cap_data;
            end

            case (state)
                IDLE: begin
                    if (transfer0 || transfer1) begin
                        grant_id   <= win;
                        last_grant <= win;
                        write      <= win ? write1 : write0;
                        addr       <= win ? addr1  : addr0;
                        wdata      <= win ? wdata1 : wdata0;
                        state      <= ISSUE;
                    end
                end
                ISSUE:   state <= ready ? RESP : WAIT;
                WAIT:    if (cap_en) state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign transfer = (state == ISSUE);
    assign busy     = (state != IDLE);
    assign ready0   = (state == RESP) && !grant_id;
    assign ready1   = (state == RESP) &&  grant_id;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: a round-robin instance (TIMEOUT_CYCLES = 8)
// driven by requester/slave models, plus a fixed-priority instance.
module tb_apb_master_arbiter;

    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int fails    = 0;

    // round-robin instance
    logic        t0, w0, t1, w1, r0, r1, xfer, xw, brdy, gid, busy, terr, eclr;
    logic [31:0] a0, d0, a1, d1, rd0, rd1, xa, xd, brd;

    apb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(0),
                         .TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)) u_rr (
        .PCLK(clk), .PRESET(rst),
        .transfer0(t0), .write0(w0), .addr0(a0), .wdata0(d0), .rdata0(rd0), .ready0(r0),
        .transfer1(t1), .write1(w1), .addr1(a1), .wdata1(d1), .rdata1(rd1), .ready1(r1),
        .transfer(xfer), .write(xw), .addr(xa), .wdata(xd), .rdata(brd), .ready(brdy),
        .grant_id(gid), .busy(busy), .timeout_err(terr), .err_clr(eclr));

    // fixed-priority instance
    logic        t0f, w0f, t1f, w1f, r0f, r1f, xff, xwf, brdyf, gidf, busyf, terrf, eclrf;
    logic [31:0] a0f, d0f, a1f, d1f, rd0f, rd1f, xaf, xdf, brdf;

    apb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(1),
                         .TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)) u_fp (
        .PCLK(clk), .PRESET(rst),
        .transfer0(t0f), .write0(w0f), .addr0(a0f), .wdata0(d0f), .rdata0(rd0f), .ready0(r0f),
        .transfer1(t1f), .write1(w1f), .addr1(a1f), .wdata1(d1f), .rdata1(rd1f), .ready1(r1f),
        .transfer(xff), .write(xwf), .addr(xaf), .wdata(xdf), .rdata(brdf), .ready(brdyf),
        .grant_id(gidf), .busy(busyf), .timeout_err(terrf), .err_clr(eclrf));

    typedef struct {int cyc; logic wr; logic [31:0] a; logic [31:0] d; logic g;} xf_t;
    typedef struct {int cyc; logic id; logic [31:0] r0; logic [31:0] r1;} rs_t;

    xf_t         xq[$], xqf[$];
    rs_t         rq[$], rqf[$];
    int          lat_q[$];
    logic [31:0] rdq[$];

    // transaction-level model state
    logic        m_last;
    logic [31:0] m_rd[2];
    logic        m_terr;

    // per-test overrides of the random request fields
    bit          ov_en;
    logic        ov_wr[2];
    logic [31:0] ov_a[2], ov_d[2], ov_rd[2];

    // APB slave + monitor for u_rr. Each transfer takes the next (latency,
    // data) pair: latency k raises ready in the k-th WAIT cycle (0 = in the
    // ISSUE cycle). Requesters drop their request once readyN is seen.
    int          s_cnt;
    bit          s_pend;
    logic [31:0] s_rd;
    always @(negedge clk) begin
        brdy = 1'b0;
        brd  = $urandom;
        if (rst) begin
            s_pend = 1'b0;
        end else begin
            if (xfer) begin
                xq.push_back('{cyc, xw, xa, xd, gid});
                s_pend = 1'b1;
                s_cnt  = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
                s_rd   = (rdq.size() != 0) ? rdq.pop_front() : 32'h0;
            end
            if (s_pend) begin
                if (s_cnt == 0) begin brdy = 1'b1; brd = s_rd; s_pend = 1'b0; end
                else s_cnt--;
            end
            if (r0) begin rq.push_back('{cyc, 1'b0, rd0, rd1}); t0 = 1'b0; end
            if (r1) begin rq.push_back('{cyc, 1'b1, rd0, rd1}); t1 = 1'b0; end
        end
    end

    // Zero-wait slave + monitor for u_fp: ready in the ISSUE cycle, rdata = ~addr.
    always @(negedge clk) begin
        brdyf = xff;
        brdf  = ~xaf;
        if (!rst) begin
            if (xff) xqf.push_back('{cyc, xwf, xaf, xdf, gidf});
            if (r0f) rqf.push_back('{cyc, 1'b0, rd0f, rd1f});
            if (r1f) rqf.push_back('{cyc, 1'b1, rd0f, rd1f});
        end
    end

    task automatic model_reset();
        m_last = 1'b1; m_rd[0] = '0; m_rd[1] = '0; m_terr = 1'b0;
        lat_q.delete(); rdq.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; t0 = 0; t1 = 0; eclr = 0; t0f = 0; t1f = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic clear_err();
        @(negedge clk); eclr = 1'b1;
        @(negedge clk); eclr = 1'b0; m_terr = 1'b0;
        compared++;
        if (terr !== 1'b0) begin fails++; $display("FAIL err_clr: timeout_err=%b want 0", terr); end
    endtask

    // One round: the selected requesters raise requests together; the model
    // predicts grant order, bus fields, start cycles, response latency and data.
    task automatic run_round(input bit q0, input bit q1, input int lat0, input int lat1);
        logic        ord[$];
        int          lat_of[2];
        logic        wr_of[2];
        logic [31:0] a_of[2], d_of[2], rd_of[2];
        int          nx, nr, c0, n, lat, exp_start;
        bit          done;
        logic        id;
        logic [31:0] exp, got, oth;
        xf_t         x;
        rs_t         r;
        lat_of[0] = lat0; lat_of[1] = lat1;
        for (int i = 0; i < 2; i++) begin
            wr_of[i] = ov_en ? ov_wr[i] : 1'($urandom_range(0, 1));
            a_of[i]  = ov_en ? ov_a[i]  : ($urandom & 32'hFFFF_FFFC);
            d_of[i]  = ov_en ? ov_d[i]  : $urandom;
            rd_of[i] = ov_en ? ov_rd[i] : $urandom;
        end
        if (q0 && q1) begin ord.push_back(!m_last); ord.push_back(m_last); end
        else if (q0)   ord.push_back(1'b0);
        else           ord.push_back(1'b1);
        m_last = ord[ord.size()-1];
        foreach (ord[k]) begin lat_q.push_back(lat_of[ord[k]]); rdq.push_back(rd_of[ord[k]]); end
        n = ord.size();

        @(negedge clk);
        nx = xq.size(); nr = rq.size(); c0 = cyc;
        if (q0) begin t0 = 1; w0 = wr_of[0]; a0 = a_of[0]; d0 = d_of[0]; end
        if (q1) begin t1 = 1; w1 = wr_of[1]; a1 = a_of[1]; d1 = d_of[1]; end
        done = 0;
        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge clk);
            if (rq.size() >= nr + n) done = 1;
        end
        repeat (2) @(negedge clk);

        compared++;
        if (!done) begin fails++; $display("FAIL round_done: responses=%0d want %0d", rq.size() - nr, n); end
        compared++;
        if (xq.size() != nx + n) begin fails++; $display("FAIL xfer_count: got %0d want %0d", xq.size() - nx, n); end
        if (done && xq.size() == nx + n) begin
            for (int k = 0; k < n; k++) begin
                x = xq[nx+k]; r = rq[nr+k]; id = ord[k];
                lat = (lat_of[id] > TO) ? TO : lat_of[id];
                exp = (lat_of[id] > TO) ? ERR : rd_of[id];
                got = id ? r.r1 : r.r0;
                oth = id ? r.r0 : r.r1;
                exp_start = (k == 0) ? c0 + 1 : rq[nr+k-1].cyc + 2;
                compared++;
                if (x.g !== id) begin fails++; $display("FAIL grant[%0d]: got %b want %b", k, x.g, id); end
                compared++;
                if ({x.wr, x.a, x.d} !== {wr_of[id], a_of[id], d_of[id]}) begin
                    fails++; $display("FAIL bus_fields[%0d]: got %b %h %h want %b %h %h", k,
                                      x.wr, x.a, x.d, wr_of[id], a_of[id], d_of[id]);
                end
                compared++;
                if (x.cyc != exp_start) begin fails++; $display("FAIL start_cycle[%0d]: got %0d want %0d", k, x.cyc, exp_start); end
                compared++;
                if (r.id !== id) begin fails++; $display("FAIL resp_id[%0d]: got %b want %b", k, r.id, id); end
                compared++;
                if (r.cyc != x.cyc + lat + 1) begin fails++; $display("FAIL resp_latency[%0d]: got %0d want %0d", k, r.cyc - x.cyc, lat + 1); end
                compared++;
                if (got !== exp) begin fails++; $display("FAIL rdata[%0d]: got %h want %h", k, got, exp); end
                compared++;
                if (oth !== m_rd[!id]) begin fails++; $display("FAIL rdata_hold[%0d]: got %h want %h", k, oth, m_rd[!id]); end
                m_rd[id] = exp;
                if (lat_of[id] > TO) m_terr = 1'b1;
            end
        end
        compared++;
        if (terr !== m_terr) begin fails++; $display("FAIL timeout_err: got %b want %b", terr, m_terr); end
        compared++;
        if (busy !== 1'b0) begin fails++; $display("FAIL busy_after: got %b want 0", busy); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; t0 = 0; t1 = 0; eclr = 0; t0f = 0; t1f = 0;
        repeat (2) @(negedge clk);
        compared++;
        if ({busy, xfer, xw, r0, r1, terr, gid} !== 7'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b want 0000000", {busy, xfer, xw, r0, r1, terr, gid});
        end
        compared++;
        if ({xa, xd} !== 64'h0) begin fails++; $display("FAIL reset_bus: got %h %h want 0", xa, xd); end
        compared++;
        if ({rd0, rd1} !== 64'h0) begin fails++; $display("FAIL reset_rdata: got %h %h want 0", rd0, rd1); end
        compared++;
        if ({busyf, xff, r0f, r1f, terrf, gidf} !== 6'b0) begin
            fails++; $display("FAIL reset_fp: got %b want 000000", {busyf, xff, r0f, r1f, terrf, gidf});
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        ov_en = 1; ov_wr[0] = 0; ov_a[0] = 32'h1000_0004; ov_d[0] = 0; ov_rd[0] = 32'h0000_00A5;
        run_round(1, 0, 2, 0);
        ov_en = 0;
    endtask

    task automatic test_rr_alternate();
        do_reset();
        ov_en = 1; ov_wr[0] = 1; ov_wr[1] = 1; ov_d[0] = 32'h11; ov_d[1] = 32'h22;
        for (int i = 0; i < 2; i++) begin
            ov_a[0] = $urandom & 32'hFFFF_FFFC; ov_a[1] = ov_a[0] ^ 32'h0000_0100;
            ov_rd[0] = $urandom; ov_rd[1] = $urandom;
            run_round(1, 1, $urandom_range(0, 3), $urandom_range(0, 3));
        end
        ov_en = 0;
    endtask

    task automatic test_fixed_prio();
        logic [31:0] exp_a[$];
        int          nx, nr, k;
        bit          done;
        do_reset();
        nx = xqf.size(); nr = rqf.size(); k = 0; done = 0;
        @(negedge clk);
        t0f = 1; w0f = 0; d0f = 0; a0f = $urandom; exp_a.push_back(a0f);
        t1f = 1; w1f = 0; d1f = 0; a1f = $urandom;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (r0f) begin
                k++;
                if (k < 3) begin a0f = $urandom; exp_a.push_back(a0f); end
                else t0f = 0;
            end
            if (r1f) begin t1f = 0; done = 1; end
        end
        exp_a.push_back(a1f);
        repeat (2) @(negedge clk);
        compared++;
        if (!done || xqf.size() != nx + 4 || rqf.size() != nr + 4) begin
            fails++; $display("FAIL fp_count: xfers=%0d resps=%0d want 4 4", xqf.size() - nx, rqf.size() - nr);
        end else begin
            for (int i = 0; i < 4; i++) begin
                compared++;
                if (xqf[nx+i].g !== (i == 3)) begin fails++; $display("FAIL fp_grant[%0d]: got %b want %b", i, xqf[nx+i].g, i == 3); end
                compared++;
                if (xqf[nx+i].a !== exp_a[i]) begin fails++; $display("FAIL fp_addr[%0d]: got %h want %h", i, xqf[nx+i].a, exp_a[i]); end
                compared++;
                if ((rqf[nr+i].id ? rqf[nr+i].r1 : rqf[nr+i].r0) !== ~exp_a[i]) begin
                    fails++; $display("FAIL fp_rdata[%0d]: got %h want %h", i,
                                      rqf[nr+i].id ? rqf[nr+i].r1 : rqf[nr+i].r0, ~exp_a[i]);
                end
            end
            compared++;
            if (xqf[nx+3].cyc != rqf[nr+2].cyc + 2) begin
                fails++; $display("FAIL fp_r1_start: got %0d want %0d", xqf[nx+3].cyc, rqf[nr+2].cyc + 2);
            end
        end
    endtask

    task automatic test_timeout();
        int nr, c0;
        do_reset();
        run_round(1, 0, 12, 0);
        clear_err();
        // err_clr in the very cycle the watchdog fires: the set must win
        lat_q.push_back(20); rdq.push_back(32'h0);
        @(negedge clk);
        nr = rq.size(); c0 = cyc;
        t1 = 1; w1 = 0; a1 = $urandom; d1 = 0;
        repeat (9) @(negedge clk);
        eclr = 1'b1;
        @(negedge clk);
        eclr = 1'b0;
        compared++;
        if (terr !== 1'b1) begin fails++; $display("FAIL set_over_clr: timeout_err=%b want 1 (cyc %0d)", terr, cyc - c0); end
        repeat (2) @(negedge clk);
        compared++;
        if (rq.size() != nr + 1 || rq[nr].id !== 1'b1 || rq[nr].r1 !== ERR) begin
            fails++; $display("FAIL timeout_resp: count=%0d want 1, rdata1=%h want %h", rq.size() - nr, rd1, ERR);
        end
        m_last = 1'b1; m_rd[1] = ERR; m_terr = 1'b1;
        clear_err();
    endtask

    task automatic test_ready_at_timeout();
        run_round(1, 1, TO, TO);
        run_round(0, 1, TO, 0);
    endtask

    task automatic test_reset_mid_wait();
        int nr;
        lat_q.push_back(20); rdq.push_back(32'h0);
        @(negedge clk);
        nr = rq.size();
        t0 = 1; w0 = 1; a0 = $urandom; d0 = $urandom;
        repeat (4) @(negedge clk);
        compared++;
        if (busy !== 1'b1 || xfer !== 1'b0) begin fails++; $display("FAIL pre_abort: busy=%b transfer=%b want 1 0", busy, xfer); end
        rst = 1'b1; t0 = 0;
        @(negedge clk);
        compared++;
        if ({busy, xfer, r0, r1} !== 4'b0) begin fails++; $display("FAIL abort_state: got %b want 0000", {busy, xfer, r0, r1}); end
        rst = 1'b0;
        model_reset();
        repeat (12) @(negedge clk);
        compared++;
        if (rq.size() != nr) begin fails++; $display("FAIL abort_no_ready: responses=%0d want 0", rq.size() - nr); end
        run_round(1, 1, $urandom_range(0, 4), $urandom_range(0, 4));
    endtask

    task automatic test_random();
        int q;
        for (int i = 0; i < 14; i++) begin
            q = $urandom_range(1, 3);
            run_round(q[0], q[1], $urandom_range(0, 10), $urandom_range(0, 10));
            if ($urandom_range(0, 2) == 0) clear_err();
        end
    endtask

    initial begin
        rst = 1; eclr = 0; eclrf = 0; ov_en = 0;
        t0 = 0; w0 = 0; a0 = 0; d0 = 0; t1 = 0; w1 = 0; a1 = 0; d1 = 0;
        t0f = 0; w0f = 0; a0f = 0; d0f = 0; t1f = 0; w1f = 0; a1f = 0; d1f = 0;
        test_reset();
        test_single_read();
        test_rr_alternate();
        test_fixed_prio();
        test_timeout();
        test_ready_at_timeout();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, compared=%0d", compared);
        $fatal(1);
    end

endmodule
